// File: rtl/cory_merge_if.sv
// Handshake bundle for the merge: R upstream streams in, one tagged stream out.
// The merge itself uses the slave view; whoever drives the inputs and sinks the output uses master.
interface cory_merge_if #(
   parameter int N = 8,
   parameter int S = 2
);
   localparam int R = 1 << S;
   localparam int D = N * R;

   logic [R-1:0] i_a_v;
   logic [D-1:0] i_a_d;
   logic [R-1:0] i_a_l;
   logic [R-1:0] o_a_r;
   logic         o_z_v;
   logic [N-1:0] o_z_d;
   logic         o_z_l;
   logic [S-1:0] o_z_s;
   logic         i_z_r;

   modport master (
      output i_a_v, i_a_d, i_a_l, i_z_r,
      input  o_a_r, o_z_v, o_z_d, o_z_l, o_z_s
   );

   modport slave (
      input  i_a_v, i_a_d, i_a_l, i_z_r,
      output o_a_r, o_z_v, o_z_d, o_z_l, o_z_s
   );
endinterface

// File: rtl/cory_merge.sv
// R-to-1 stream merge: round-robin arbitration, held on one input until its packet ends.
// Each output beat is registered and tagged with the index of the input it came from.
module cory_merge #(
   parameter int N = 8,
   parameter int S = 2
) (
   input logic         clk,
   input logic         reset_n,
   cory_merge_if.slave bus
);
   localparam int R = 1 << S;

   typedef enum logic {ARB, LOCK} state_t;

   state_t       state, state_next;
   logic [S-1:0] lock_idx, lock_next;
   logic [S-1:0] ptr, ptr_next;
   logic [S-1:0] grant, cand;
   logic         grant_v, ld, xfer;

   logic         z_v, z_l;
   logic [N-1:0] z_d;
   logic [S-1:0] z_s;

   assign ld   = !z_v || bus.i_z_r;
   assign xfer = ld && grant_v;

   // Scan downward so the last hit is the first input after ptr; the wrap is free since R = 2**S.
   always_comb begin
      grant_v = 1'b0;
      grant   = '0;
      cand    = '0;
      if (state == LOCK) begin
         grant_v = bus.i_a_v[lock_idx];
         grant   = lock_idx;
      end else begin
         for (int i = R; i >= 1; i--) begin
            cand = ptr + S'(i);
            if (bus.i_a_v[cand]) begin
               grant_v = 1'b1;
               grant   = cand;
            end
         end
      end
   end

   assign bus.o_a_r = xfer ? (R'(1) << grant) : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         z_v <= 1'b0;
         z_d <= '0;
         z_l <= 1'b0;
         z_s <= '0;
      end else if (ld) begin
         if (xfer) begin
            z_v <= 1'b1;
            z_d <= bus.i_a_d[int'(grant) * N +: N];
            z_l <= bus.i_a_l[grant];
            z_s <= grant;
         end else begin
            z_v <= 1'b0;
         end
      end
   end

   assign bus.o_z_v = z_v;
   assign bus.o_z_d = z_d;
   assign bus.o_z_l = z_l;
   assign bus.o_z_s = z_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ARB;
         lock_idx <= '0;
         ptr      <= S'(R - 1);
      end else begin
         state    <= state_next;
         lock_idx <= lock_next;
         ptr      <= ptr_next;
      end
   end

   // A transfer always moves the pointer; only the last flag decides whether we hold the input.
   always_comb begin
      state_next = state;
      lock_next  = lock_idx;
      ptr_next   = ptr;
      if (xfer) begin
         ptr_next = grant;
         case (state)
            ARB: begin
               if (!bus.i_a_l[grant]) begin
                  state_next = LOCK;
                  lock_next  = grant;
               end
            end
            LOCK: begin
               if (bus.i_a_l[grant]) state_next = ARB;
            end
            default: state_next = ARB;
         endcase
      end
   end

`ifdef SIM
   if (S < 1 || S > 4) begin : g_bad_s
      $error("cory_merge: S=%0d outside supported range 1..4", S);
   end

   always_ff @(posedge clk) begin
      if (reset_n && !$onehot0(bus.o_a_r))
         $error("cory_merge: more than one o_a_r bit high (%b)", bus.o_a_r);
   end
`endif
endmodule

// File: tb/tb_cory_merge.sv
// Self-checking bench for cory_merge: a table of directed vectors, two hand-built corner sequences
// (lock held across an idle gap, reset mid-packet), then random traffic against a queue-free reference model.
module tb_cory_merge;
   localparam int N = 8;
   localparam int S = 2;
   localparam int R = 1 << S;
   localparam int D = N * R;

   logic clk;
   logic reset_n;

   cory_merge_if #(.N(N), .S(S)) bus ();

   cory_merge #(.N(N), .S(S)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [R-1:0] v;
      logic [D-1:0] d;
      logic [R-1:0] l;
      logic         zr;
      logic [R-1:0] ar;
      logic         zv;
      logic [N-1:0] zd;
      logic [S-1:0] zs;
      logic         zl;
   } vec_t;

   vec_t vecs[$];

   int checks = 0;
   int passes = 0;

   logic [R-1:0] ar_seen;
   logic [R-1:0] ar_model;

   // Reference model: "last served" index plus an optional held input, and the expected output beat.
   bit       m_locked;
   int       m_lock;
   int       m_last;
   bit       m_zv;
   bit [N-1:0] m_zd;
   bit       m_zl;
   int       m_zs;

   function automatic void model_reset();
      m_locked = 0;
      m_lock   = 0;
      m_last   = R - 1;
      m_zv     = 0;
      m_zd     = '0;
      m_zl     = 0;
      m_zs     = 0;
   endfunction

   function automatic int model_grant();
      int c;
      if (m_locked) return bus.i_a_v[m_lock] ? m_lock : -1;
      for (int k = 1; k <= R; k++) begin
         c = (m_last + k) % R;
         if (bus.i_a_v[c]) return c;
      end
      return -1;
   endfunction

   // Computes the expected ready for this cycle, then moves the model to its post-edge state.
   function automatic void model_cycle();
      int  g;
      bit  room;
      g        = model_grant();
      room     = !m_zv || bus.i_z_r;
      ar_model = (room && g >= 0) ? R'(1) << g : '0;
      if (room) begin
         if (g >= 0) begin
            m_zv   = 1;
            m_zd   = bus.i_a_d[g*N +: N];
            m_zl   = bus.i_a_l[g];
            m_zs   = g;
            m_last = g;
            if (m_locked) begin
               m_locked = !bus.i_a_l[g];
            end else if (!bus.i_a_l[g]) begin
               m_locked = 1;
               m_lock   = g;
            end
         end else begin
            m_zv = 0;
         end
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
   endtask

   // Inputs change 1 time unit after a rising edge; ready is sampled before the next edge, outputs after it.
   task automatic applyStimulus(input logic [R-1:0] v, input logic [D-1:0] d,
                                input logic [R-1:0] l, input logic zr);
      bus.i_a_v = v;
      bus.i_a_d = d;
      bus.i_a_l = l;
      bus.i_z_r = zr;
      #1;
      ar_seen = bus.o_a_r;
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input string tag, input vec_t t);
      applyStimulus(t.v, t.d, t.l, t.zr);
      checkOutput({tag, "_ready"}, 32'(ar_seen), 32'(t.ar));
      checkOutput({tag, "_zv"}, 32'(bus.o_z_v), 32'(t.zv));
      checkOutput({tag, "_zd"}, 32'(bus.o_z_d), 32'(t.zd));
      checkOutput({tag, "_zs"}, 32'(bus.o_z_s), 32'(t.zs));
      checkOutput({tag, "_zl"}, 32'(bus.o_z_l), 32'(t.zl));
   endtask

   function automatic void add_vec(logic [R-1:0] v, logic [D-1:0] d, logic [R-1:0] l, logic zr,
                                   logic [R-1:0] ar, logic zv, logic [N-1:0] zd,
                                   logic [S-1:0] zs, logic zl);
      vecs.push_back('{v: v, d: d, l: l, zr: zr, ar: ar, zv: zv, zd: zd, zs: zs, zl: zl});
   endfunction

   initial begin
      // Single beat from input 0, then round robin over four always-valid single-beat inputs.
      add_vec(4'b0001, 32'h000000A5, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA5, 2'd0, 1'b1);
      add_vec(4'b1111, 32'h03020100, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h01, 2'd1, 1'b1);
      add_vec(4'b1111, 32'h03020100, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h02, 2'd2, 1'b1);
      add_vec(4'b1111, 32'h03020100, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h03, 2'd3, 1'b1);
      add_vec(4'b1111, 32'h03020100, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0, 1'b1);
      add_vec(4'b1111, 32'h03020100, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h01, 2'd1, 1'b1);
      add_vec(4'b1111, 32'h03020100, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h02, 2'd2, 1'b1);
      add_vec(4'b1111, 32'h03020100, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h03, 2'd3, 1'b1);
      add_vec(4'b1111, 32'h03020100, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0, 1'b1);
      add_vec(4'b1111, 32'h03020100, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h01, 2'd1, 1'b1);
      // Three-beat packet on input 2 while 0,1,3 stay valid; input 3 follows it.
      add_vec(4'b1111, 32'h03100100, 4'b1011, 1'b1, 4'b0100, 1'b1, 8'h10, 2'd2, 1'b0);
      add_vec(4'b1111, 32'h03110100, 4'b1011, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd2, 1'b0);
      add_vec(4'b1111, 32'h03120100, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2, 1'b1);
      add_vec(4'b1111, 32'h03020100, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h03, 2'd3, 1'b1);
      // Output backpressure: 8'h33 parked for five cycles while input 1 waits.
      add_vec(4'b0001, 32'h00000033, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h33, 2'd0, 1'b1);
      for (int i = 0; i < 5; i++)
         add_vec(4'b0010, 32'h00004400, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd0, 1'b1);
      add_vec(4'b0010, 32'h00004400, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h44, 2'd1, 1'b1);
      add_vec(4'b0000, 32'h00000000, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h44, 2'd1, 1'b1);

      bus.i_a_v = '0;
      bus.i_a_d = '0;
      bus.i_a_l = '0;
      bus.i_z_r = 1'b0;
      reset_n   = 1'b0;
      model_reset();
      #1;
      checkOutput("reset_zv", 32'(bus.o_z_v), 32'd0);
      checkOutput("reset_zd", 32'(bus.o_z_d), 32'd0);
      checkOutput("reset_zl", 32'(bus.o_z_l), 32'd0);
      checkOutput("reset_zs", 32'(bus.o_z_s), 32'd0);
      checkOutput("reset_ready", 32'(bus.o_a_r), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Input 0 opens a packet, goes idle for three cycles; input 3 must not slip in.
      run_vec("gap_open", '{4'b0001, 32'h00000050, 4'b0000, 1'b1, 4'b0001, 1'b1, 8'h50, 2'd0, 1'b0});
      for (int i = 0; i < 3; i++)
         run_vec($sformatf("gap_idle%0d", i),
                 '{4'b1000, 32'h77000000, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h50, 2'd0, 1'b0});
      run_vec("gap_close", '{4'b1001, 32'h77000051, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h51, 2'd0, 1'b1});
      run_vec("gap_next", '{4'b1000, 32'h77000000, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h77, 2'd3, 1'b1});

      // Reset lands while a packet from input 0 is in flight; the output clears without a clock.
      run_vec("rst_open", '{4'b0001, 32'h00000060, 4'b0000, 1'b1, 4'b0001, 1'b1, 8'h60, 2'd0, 1'b0});
      bus.i_a_v = '0;
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("rst_async_zv", 32'(bus.o_z_v), 32'd0);
      checkOutput("rst_async_zd", 32'(bus.o_z_d), 32'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      run_vec("rst_after", '{4'b0010, 32'h00006100, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h61, 2'd1, 1'b1});

      // Random traffic with occasional backpressure, checked cycle by cycle against the model.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(R'($urandom_range(0, (1 << R) - 1)), D'($urandom),
                       R'($urandom), $urandom_range(0, 3) != 0);
         checkOutput($sformatf("rnd%0d_ready", i), 32'(ar_seen), 32'(ar_model));
         checkOutput($sformatf("rnd%0d_zv", i), 32'(bus.o_z_v), 32'(m_zv));
         checkOutput($sformatf("rnd%0d_zd", i), 32'(bus.o_z_d), 32'(m_zd));
         checkOutput($sformatf("rnd%0d_zs", i), 32'(bus.o_z_s), 32'(m_zs));
         checkOutput($sformatf("rnd%0d_zl", i), 32'(bus.o_z_l), 32'(m_zl));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
